prv32_muldiv_seq: RTL

Iterative RV32M multiply/divide sequencer that borrows the shared 32-bit integer ALU's add/subtract path one step per cycle, instead of owning a private multiplier or divider. It sits beside the execute stage. It accepts one M-extension operation at a time through a valid/ready request port. It requests the ALU through a req/gnt pair, runs 32 shift-add or restoring-divide steps on it, and returns the 32-bit result on a valid/ready response port.

---
 rtl/prv32_md_pkg.sv | 39 +++
 rtl/prv32_md_signfix.sv | 31 +++
 rtl/prv32_muldiv_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/prv32_md_pkg.sv
// Shared encodings for the sequential RV32M multiply/divide unit.
// RV32M funct3 codes, sequencer states, ALU function codes and the step count.
package prv32_md_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } md_state_t;

  localparam logic [3:0] ALU_FN_ADD = 4'b0000;
  localparam logic [3:0] ALU_FN_SUB = 4'b0001;

  localparam int MD_STEPS = 32;

  function automatic logic md_is_div(input logic [2:0] op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_a_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/prv32_md_signfix.sv
// Combinational sign handling: 32-bit absolute value plus a 64-bit negator that can
// also negate its two 32-bit halves independently (quotient and remainder).
module prv32_md_signfix (
  input  logic [31:0] abs_in,
  input  logic        abs_en,
  output logic [31:0] abs_out,
  input  logic [63:0] neg_in,
  input  logic        neg_split,
  input  logic        neg_hi_en,
  input  logic        neg_lo_en,
  output logic [63:0] neg_out
);

  logic [63:0] full_neg;
  logic [31:0] hi_neg;
  logic [31:0] lo_neg;

  always_comb begin
    abs_out  = (abs_en && abs_in[31]) ? (32'd0 - abs_in) : abs_in;
    full_neg = 64'd0 - neg_in;
    hi_neg   = 32'd0 - neg_in[63:32];
    lo_neg   = 32'd0 - neg_in[31:0];
    if (neg_split) begin
      neg_out = {neg_hi_en ? hi_neg : neg_in[63:32],
                 neg_lo_en ? lo_neg : neg_in[31:0]};
    end else begin
      neg_out = neg_lo_en ? full_neg : neg_in;
    end
  end

endmodule

// File: rtl/prv32_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer stepping on the shared ALU add/sub path.
// Optional PRV32_MD_EARLY_OUT_EN: divide-by-zero / overflow answer straight from PREP.
module prv32_muldiv_seq
  import prv32_md_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_fn,
  input  logic [31:0] alu_r,
  input  logic        alu_cf
);

  md_state_t   state;
  logic [2:0]  op;
  logic [31:0] a_cap;
  logic [31:0] b_cap;
  logic [31:0] hi;       // product high word, or partial remainder R
  logic [31:0] lo;       // multiplier / product low word, or dividend / quotient Q
  logic [31:0] opb_mag;  // multiplicand or divisor magnitude
  logic [4:0]  cnt;
  logic        sgn_pq;
  logic        sgn_r;
  logic        divz;
  logic        ovf;

  logic        is_div;
  logic        in_prep;
  logic        sa;
  logic        sb;
  logic        divz_now;
  logic        ovf_now;
  logic [31:0] hi_nx;
  logic [31:0] lo_nx;
  logic [31:0] sf_abs;
  logic [63:0] sf_neg;

  // Result selection with the divide-by-zero and signed-overflow overrides.
  function automatic logic [31:0] fix_result(input logic [2:0]  f_op,
                                             input logic [31:0] f_hi,
                                             input logic [31:0] f_lo,
                                             input logic        f_divz,
                                             input logic        f_ovf,
                                             input logic [31:0] f_a);
    logic [31:0] res;
    case (f_op)
      MD_MUL:                      res = f_lo;
      MD_MULH, MD_MULHSU, MD_MULHU: res = f_hi;
      MD_DIV, MD_DIVU: begin
        if (f_divz)     res = 32'hFFFF_FFFF;
        else if (f_ovf) res = 32'h8000_0000;
        else            res = f_lo;
      end
      default: begin
        if (f_divz)     res = f_a;
        else if (f_ovf) res = 32'd0;
        else            res = f_hi;
      end
    endcase
    return res;
  endfunction

  always_comb begin
    is_div   = md_is_div(op);
    in_prep  = (state == ST_PREP);
    sa       = md_a_signed(op) & a_cap[31];
    sb       = md_b_signed(op) & b_cap[31];
    divz_now = is_div && (b_cap == 32'd0);
    ovf_now  = ((op == MD_DIV) || (op == MD_REM)) &&
               (a_cap == 32'h8000_0000) && (b_cap == 32'hFFFF_FFFF);
  end

  // PREP uses the unit for |a| and |b|; FIX reuses it for the result sign correction.
  prv32_md_signfix u_signfix (
    .abs_in    (a_cap),
    .abs_en    (md_a_signed(op)),
    .abs_out   (sf_abs),
    .neg_in    (in_prep ? {32'd0, b_cap} : {hi, lo}),
    .neg_split (in_prep | is_div),
    .neg_hi_en (~in_prep & sgn_r),
    .neg_lo_en (in_prep ? sb : sgn_pq),
    .neg_out   (sf_neg)
  );

  always_comb begin
    alu_req = (state == ST_ITER);
    alu_a   = 32'd0;
    alu_b   = 32'd0;
    alu_fn  = ALU_FN_ADD;
    if (state == ST_ITER) begin
      alu_b = opb_mag;
      if (is_div) begin
        alu_a  = {hi[30:0], lo[31]};
        alu_fn = ALU_FN_SUB;
      end else begin
        alu_a  = hi;
        alu_fn = ALU_FN_ADD;
      end
    end
  end

  // One shift-add or restoring-divide step from the ALU's answer.
  always_comb begin
    if (is_div) begin
      if (hi[31] | alu_cf) begin
        hi_nx = alu_r;
        lo_nx = {lo[30:0], 1'b1};
      end else begin
        hi_nx = {hi[30:0], lo[31]};
        lo_nx = {lo[30:0], 1'b0};
      end
    end else begin
      if (lo[0]) begin
        hi_nx = {alu_cf, alu_r[31:1]};
        lo_nx = {alu_r[0], lo[31:1]};
      end else begin
        hi_nx = {1'b0, hi[31:1]};
        lo_nx = {hi[0], lo[31:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op        <= MD_MUL;
      a_cap     <= 32'd0;
      b_cap     <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      opb_mag   <= 32'd0;
      cnt       <= 5'd0;
      sgn_pq    <= 1'b0;
      sgn_r     <= 1'b0;
      divz      <= 1'b0;
      ovf       <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            op        <= req_op;
            a_cap     <= req_a;
            b_cap     <= req_b;
            req_ready <= 1'b0;
            state     <= ST_PREP;
          end
        end
        ST_PREP: begin
          sgn_pq  <= sa ^ sb;
          sgn_r   <= sa;
          divz    <= divz_now;
          ovf     <= ovf_now;
          hi      <= 32'd0;
          lo      <= sf_abs;
          opb_mag <= sf_neg[31:0];
          cnt     <= 5'd0;
`ifdef PRV32_MD_EARLY_OUT_EN
          if (divz_now || ovf_now) begin
            rsp_data  <= fix_result(op, 32'd0, 32'd0, divz_now, ovf_now, a_cap);
            rsp_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            state <= ST_ITER;
          end
`else
          state <= ST_ITER;
`endif
        end
        ST_ITER: begin
          if (alu_gnt) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(MD_STEPS - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          rsp_data  <= fix_result(op, sf_neg[63:32], sf_neg[31:0], divz, ovf, a_cap);
          rsp_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
